// File: rtl/player_motion.sv
// Per-tick player state engine: position, facing and viewplane updated on each accepted tick.
// Define PLAYER_COLLISION_EN to check each axis against the map through the req/ack port.
module player_motion #(
  parameter int QM         = 6,
  parameter int QN         = 10,
  parameter int MAP_BITS   = 4,
  parameter int MOVE_STEP  = 5,
  parameter int DIAG_SCALE = 724,
  parameter int ROT_COS    = 1020,
  parameter int ROT_SIN    = 89,
  parameter int START_X    = 1536,
  parameter int START_Y    = 11776,
  parameter int START_FX   = 0,
  parameter int START_FY   = -1024,
  parameter int START_VX   = 512,
  parameter int START_VY   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       moveF,
  input  logic                       moveB,
  input  logic                       strafeL,
  input  logic                       strafeR,
  input  logic                       rotL,
  input  logic                       rotR,
  output logic                       map_req,
  output logic [MAP_BITS-1:0]        map_col,
  output logic [MAP_BITS-1:0]        map_row,
  input  logic                       map_ack,
  input  logic [1:0]                 map_val,
  output logic signed [QM+QN-1:0]    playerX,
  output logic signed [QM+QN-1:0]    playerY,
  output logic signed [QM+QN-1:0]    facingX,
  output logic signed [QM+QN-1:0]    facingY,
  output logic signed [QM+QN-1:0]    vplaneX,
  output logic signed [QM+QN-1:0]    vplaneY,
  output logic                       busy,
  output logic                       done,
  output logic                       missed
);

  localparam int W = QM + QN;
  localparam logic signed [W-1:0] K_STEP  = W'(MOVE_STEP);
  localparam logic signed [W-1:0] K_DIAG  = W'(DIAG_SCALE);
  localparam logic signed [W-1:0] K_COS   = W'(ROT_COS);
  localparam logic signed [W-1:0] K_SIN   = W'(ROT_SIN);

  typedef enum logic [2:0] {IDLE, CALC, ROT, CHKX, CHKY, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [5:0]          ctrl_q;
  logic                done_q, missed_q;
  logic signed [W-1:0] px_q, py_q, fx_q, fy_q, vx_q, vy_q;
  logic signed [W-1:0] nx_q, ny_q, nfx_q, nfy_q, nvx_q, nvy_q;
  logic signed [W-1:0] fwd_x, fwd_y, side_x, side_y, sum_x, sum_y, dx, dy;
  logic signed [W-1:0] rot_s;
  logic                fwd_on, side_on, rot_on;

  // (a*b + c*d) >>> QN with a 2W-bit accumulator, truncated (wraps) to W
  function automatic logic signed [W-1:0] fx_mac(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                                 input logic signed [W-1:0] c, input logic signed [W-1:0] d);
    logic signed [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b) + (2*W)'(c) * (2*W)'(d);
    p = p >>> QN;
    return p[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] fx_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return fx_mac(a, b, '0, '0);
  endfunction

  always_comb begin
    fwd_on  = ctrl_q[5] ^ ctrl_q[4];
    side_on = ctrl_q[3] ^ ctrl_q[2];
    fwd_x   = '0;
    fwd_y   = '0;
    side_x  = '0;
    side_y  = '0;
    if (ctrl_q[5] && !ctrl_q[4]) begin
      fwd_x = fx_q;
      fwd_y = fy_q;
    end else if (ctrl_q[4] && !ctrl_q[5]) begin
      fwd_x = -fx_q;
      fwd_y = -fy_q;
    end
    // strafe right follows the perpendicular (-facingY, facingX)
    if (ctrl_q[2] && !ctrl_q[3]) begin
      side_x = -fy_q;
      side_y = fx_q;
    end else if (ctrl_q[3] && !ctrl_q[2]) begin
      side_x = fy_q;
      side_y = -fx_q;
    end
    sum_x = fwd_x + side_x;
    sum_y = fwd_y + side_y;
    dx    = fx_mul(sum_x, K_STEP);
    dy    = fx_mul(sum_y, K_STEP);
    if (fwd_on && side_on) begin
      dx = fx_mul(dx, K_DIAG);
      dy = fx_mul(dy, K_DIAG);
    end
    rot_on = ctrl_q[1] ^ ctrl_q[0];
    rot_s  = ctrl_q[0] ? K_SIN : -K_SIN;
  end

`ifdef PLAYER_COLLISION_EN
  logic oob_x, oob_y, wall;

  function automatic logic [MAP_BITS-1:0] cell(input logic signed [W-1:0] v);
    return v[QN+MAP_BITS-1:QN];
  endfunction

  function automatic logic off_map(input logic signed [W-1:0] v);
    logic signed [W-1:0] t;
    t = v >>> (QN + MAP_BITS);
    return t != '0;
  endfunction

  assign oob_x = off_map(nx_q);
  assign oob_y = off_map(ny_q);
  assign wall  = map_val != 2'b00;
`else
  logic unused_map;
  assign unused_map = ^{map_ack, map_val};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (tick) state_d = CALC;
      CALC:   state_d = ROT;
`ifdef PLAYER_COLLISION_EN
      ROT:    state_d = CHKX;
      CHKX:   if (oob_x || map_ack) state_d = CHKY;
      CHKY:   if (oob_y || map_ack) state_d = COMMIT;
`else
      ROT:    state_d = COMMIT;
`endif
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = state_q != IDLE;
    map_req = 1'b0;
    map_col = '0;
    map_row = '0;
`ifdef PLAYER_COLLISION_EN
    // X probe uses the old row; Y probe uses the already-resolved X column
    if (state_q == CHKX) begin
      map_req = !oob_x;
      map_col = cell(nx_q);
      map_row = cell(py_q);
    end else if (state_q == CHKY) begin
      map_req = !oob_y;
      map_col = cell(nx_q);
      map_row = cell(ny_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      px_q     <= W'(START_X);
      py_q     <= W'(START_Y);
      fx_q     <= W'(START_FX);
      fy_q     <= W'(START_FY);
      vx_q     <= W'(START_VX);
      vy_q     <= W'(START_VY);
    end else begin
      done_q   <= state_q == COMMIT;
      missed_q <= tick && (state_q != IDLE);
      if (state_q == IDLE && tick) ctrl_q <= {moveF, moveB, strafeL, strafeR, rotL, rotR};
      if (state_q == COMMIT) begin
        px_q <= nx_q;
        py_q <= ny_q;
        fx_q <= nfx_q;
        fy_q <= nfy_q;
        vx_q <= nvx_q;
        vy_q <= nvy_q;
      end
    end
  end

  // Scratch candidates; only ever committed from COMMIT, so they need no reset
  always_ff @(posedge clk) begin
    case (state_q)
      CALC: begin
        nx_q <= px_q + dx;
        ny_q <= py_q + dy;
      end
      ROT: begin
        nfx_q <= rot_on ? fx_mac(fx_q, K_COS, fy_q, -rot_s) : fx_q;
        nfy_q <= rot_on ? fx_mac(fx_q, rot_s, fy_q, K_COS)  : fy_q;
        nvx_q <= rot_on ? fx_mac(vx_q, K_COS, vy_q, -rot_s) : vx_q;
        nvy_q <= rot_on ? fx_mac(vx_q, rot_s, vy_q, K_COS)  : vy_q;
      end
`ifdef PLAYER_COLLISION_EN
      CHKX: if (oob_x || (map_ack && wall)) nx_q <= px_q;
      CHKY: if (oob_y || (map_ack && wall)) ny_q <= py_q;
`endif
      default: ;
    endcase
  end

  assign playerX = px_q;
  assign playerY = py_q;
  assign facingX = fx_q;
  assign facingY = fy_q;
  assign vplaneX = vx_q;
  assign vplaneY = vy_q;
  assign done    = done_q;
  assign missed  = missed_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion; collision scenarios compile in when PLAYER_COLLISION_EN is defined.
module tb_player_motion;
`ifdef PLAYER_COLLISION_EN
  localparam int SX  = 1027;
  localparam int LAT = 5;
`else
  localparam int SX  = 1536;
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0, tick = 1'b0;
  logic moveF = 0, moveB = 0, strafeL = 0, strafeR = 0, rotL = 0, rotR = 0;
  logic map_req, map_ack = 1'b0;
  logic [3:0] map_col, map_row;
  logic [1:0] map_val = 2'b00;
  logic signed [15:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic busy, done, missed;

  int vectors = 0, miscompares = 0;
  int ack_delay = 0, ack_cnt = 0;

  player_motion #(.START_X(SX)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .moveF(moveF), .moveB(moveB), .strafeL(strafeL), .strafeR(strafeR), .rotL(rotL), .rotR(rotR),
    .map_req(map_req), .map_col(map_col), .map_row(map_row), .map_ack(map_ack), .map_val(map_val),
    .playerX(playerX), .playerY(playerY), .facingX(facingX), .facingY(facingY),
    .vplaneX(vplaneX), .vplaneY(vplaneY), .busy(busy), .done(done), .missed(missed)
  );

  // Map responder: column 0 is wall, acks ack_delay cycles after a request appears
  always @(negedge clk) begin
    if (!map_req) begin
      map_ack = 1'b0; map_val = 2'b00; ack_cnt = 0;
    end else begin
      if (map_ack) ack_cnt = 0;
      if (ack_cnt >= ack_delay) begin
        map_ack = 1'b1; map_val = (map_col == 4'd0) ? 2'd1 : 2'd0;
      end else begin
        map_ack = 1'b0; map_val = 2'b00; ack_cnt++;
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b0; tick = 1'b0;
    {moveF, moveB, strafeL, strafeR, rotL, rotR} = 6'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // c = {moveF, moveB, strafeL, strafeR, rotL, rotR}; returns at the negedge after the tick edge
  task automatic pulse_tick(input logic [5:0] c);
    {moveF, moveB, strafeL, strafeR, rotL, rotR} = c;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    {moveF, moveB, strafeL, strafeR, rotL, rotR} = 6'b0;
  endtask

  task automatic wait_done(output int n, output logic saw_req, output logic [3:0] c0, output logic [3:0] r0);
    n = 0; saw_req = 1'b0; c0 = 4'hf; r0 = 4'hf;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      if (map_req === 1'b1 && !saw_req) begin c0 = map_col; r0 = map_row; end
      if (map_req === 1'b1) saw_req = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({playerX, playerY, facingX, facingY, vplaneX, vplaneY} !== {16'(SX), 16'sd11776, 16'sd0, -16'sd1024, 16'sd512, 16'sd0}) begin
      miscompares++;
      $display("FAIL reset_state got X=%0d Y=%0d F=(%0d,%0d) V=(%0d,%0d) want X=%0d Y=11776 F=(0,-1024) V=(512,0)",
               playerX, playerY, facingX, facingY, vplaneX, vplaneY, SX);
    end
    vectors++;
    if ({busy, done, missed, map_req, map_col, map_row} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_ctrl got busy=%b done=%b missed=%b req=%b col=%0d row=%0d want all 0",
               busy, done, missed, map_req, map_col, map_row);
    end
  endtask

  task automatic test_move(input string name, input logic [5:0] c, input int ex, input int ey);
    int n; logic sr; logic [3:0] c0, r0;
    apply_reset();
    pulse_tick(c);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL %s_busy got %b want 1", name, busy); end
    wait_done(n, sr, c0, r0);
    vectors++;
    if (n !== LAT) begin miscompares++; $display("FAIL %s_latency got %0d want %0d", name, n, LAT); end
    vectors++;
    if (playerX !== 16'(ex) || playerY !== 16'(ey)) begin
      miscompares++;
      $display("FAIL %s_pos got (%0d,%0d) want (%0d,%0d)", name, playerX, playerY, ex, ey);
    end
`ifndef PLAYER_COLLISION_EN
    vectors++;
    if (sr !== 1'b0) begin miscompares++; $display("FAIL %s_noreq got map_req seen=%b want 0", name, sr); end
`endif
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL %s_pulse got done=%b busy=%b want 0 0", name, done, busy); end
  endtask

  task automatic test_rotate(input string name, input logic [5:0] c, input int efx, input int efy, input int evx, input int evy);
    int n; logic sr; logic [3:0] c0, r0;
    apply_reset();
    pulse_tick(c);
    wait_done(n, sr, c0, r0);
    vectors++;
    if ({facingX, facingY, vplaneX, vplaneY} !== {16'(efx), 16'(efy), 16'(evx), 16'(evy)}) begin
      miscompares++;
      $display("FAIL %s_vec got F=(%0d,%0d) V=(%0d,%0d) want F=(%0d,%0d) V=(%0d,%0d)",
               name, facingX, facingY, vplaneX, vplaneY, efx, efy, evx, evy);
    end
    vectors++;
    if (playerX !== 16'(SX) || playerY !== 16'sd11776) begin
      miscompares++;
      $display("FAIL %s_pos got (%0d,%0d) want (%0d,11776)", name, playerX, playerY, SX);
    end
  endtask

  task automatic test_back_to_back();
    int n, dones; logic sr; logic [3:0] c0, r0;
    apply_reset();
    pulse_tick(6'b100000);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    vectors++;
    if ({missed, busy} !== 2'b11) begin miscompares++; $display("FAIL b2b_missed got missed=%b busy=%b want 1 1", missed, busy); end
    @(negedge clk);
    vectors++;
    if (missed !== 1'b0) begin miscompares++; $display("FAIL b2b_missed_clear got %b want 0", missed); end
    wait_done(n, sr, c0, r0);
    vectors++;
    if (done !== 1'b1 || playerY !== 16'sd11771) begin
      miscompares++;
      $display("FAIL b2b_commit got done=%b Y=%0d want 1 11771", done, playerY);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (done === 1'b1) dones++; end
    vectors++;
    if (dones !== 0 || playerY !== 16'sd11771) begin
      miscompares++;
      $display("FAIL b2b_no_queue got extra_done=%0d Y=%0d want 0 11771", dones, playerY);
    end
  endtask

  task automatic test_abort();
    int n, dones; logic sr; logic [3:0] c0, r0;
    apply_reset();
    pulse_tick(6'b100001);
    wait_done(n, sr, c0, r0);
    @(negedge clk);
    ack_delay = 4;
    pulse_tick(6'b100000);
`ifdef PLAYER_COLLISION_EN
    repeat (9) @(negedge clk);
    vectors++;
    if ({busy, map_req, map_col, map_row} !== {1'b1, 1'b1, 4'd1, 4'd11}) begin
      miscompares++;
      $display("FAIL abort_in_chky got busy=%b req=%b col=%0d row=%0d want 1 1 1 11", busy, map_req, map_col, map_row);
    end
`else
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy got %b want 1", busy); end
`endif
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({playerX, playerY, facingX, facingY, vplaneX, vplaneY} !== {16'(SX), 16'sd11776, 16'sd0, -16'sd1024, 16'sd512, 16'sd0}
        || {busy, done, map_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_restore got X=%0d Y=%0d F=(%0d,%0d) V=(%0d,%0d) busy=%b done=%b req=%b want start values, 0 0 0",
               playerX, playerY, facingX, facingY, vplaneX, vplaneY, busy, done, map_req);
    end
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (done === 1'b1) dones++; end
    vectors++;
    if (dones !== 0 || playerY !== 16'sd11776) begin
      miscompares++;
      $display("FAIL abort_no_commit got done_pulses=%0d Y=%0d want 0 11776", dones, playerY);
    end
    ack_delay = 0;
  endtask

`ifdef PLAYER_COLLISION_EN
  task automatic test_wall_slide();
    int n; logic sr; logic [3:0] c0, r0;
    apply_reset();
    pulse_tick(6'b001000);
    wait_done(n, sr, c0, r0);
    vectors++;
    if (playerX !== 16'sd1027 || playerY !== 16'sd11776) begin
      miscompares++;
      $display("FAIL wall_pos got (%0d,%0d) want (1027,11776)", playerX, playerY);
    end
    vectors++;
    if ({sr, c0, r0} !== {1'b1, 4'd0, 4'd11}) begin
      miscompares++;
      $display("FAIL wall_lookup got req=%b col=%0d row=%0d want 1 0 11", sr, c0, r0);
    end
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL wall_latency got %0d want 5", n); end
  endtask

  task automatic test_ack_delay();
    int n, dones, misses;
    logic pr, pa; logic [3:0] pc, prow;
    apply_reset();
    ack_delay = 4;
    pulse_tick(6'b100000);
    n = 0; dones = 0; misses = 0; pr = 1'b0; pa = 1'b0; pc = 4'h0; prow = 4'h0;
    while (dones == 0 && n < 60) begin
      if (n == 3) tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      n++;
      if (missed === 1'b1) misses++;
      if (done === 1'b1) dones++;
      if (pr && !pa) begin
        vectors++;
        if ({map_req, map_col, map_row} !== {1'b1, pc, prow}) begin
          miscompares++;
          $display("FAIL ack_hold got req=%b col=%0d row=%0d want 1 %0d %0d", map_req, map_col, map_row, pc, prow);
        end
      end
      pr = map_req; pa = map_ack; pc = map_col; prow = map_row;
    end
    vectors++;
    if (n !== 13) begin miscompares++; $display("FAIL ack_latency got %0d want 13", n); end
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (done === 1'b1) dones++; end
    vectors++;
    if ({dones, misses} !== {32'd1, 32'd1} || playerY !== 16'sd11771) begin
      miscompares++;
      $display("FAIL ack_single_commit got done=%0d missed=%0d Y=%0d want 1 1 11771", dones, misses, playerY);
    end
    ack_delay = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_move("fwd", 6'b100000, SX, 11771);         // -1024*5 >>> 10 = -5
    test_move("back", 6'b010000, SX, 11781);
    test_move("diag", 6'b100100, SX + 3, 11772);    // 5*724>>>10 = 3, -5*724>>>10 = -4 (floor)
    test_move("cancel", 6'b110011, SX, 11776);
    test_rotate("rotR", 6'b000001, 89, -1020, 510, 44);
    test_rotate("rotL", 6'b000010, -89, -1020, 510, -45);
    test_rotate("rot_both", 6'b000011, 0, -1024, 512, 0);
    test_back_to_back();
`ifdef PLAYER_COLLISION_EN
    test_wall_slide();
    test_ack_delay();
`endif
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
